line_span_counter: RTL and testbench

- Parametrised successor to the line-drawing X-loop counter.
- Walks a signed coordinate from coord_a to coord_b, up or down, one point per accepted handshake.
- Provides valid/ready backpressure, a last-point flag, a step index, a done pulse, abort, and an optional half-open (end-exclusive) mode.
- Sits between the line setup stage and the Bresenham error/plot stage; drives the major-axis coordinate.

---
 rtl/line_span_counter.sv | 143 ++++++++++++++
 tb/tb_line_span_counter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/line_span_counter.sv
// Major-axis span walker for the line rasteriser: emits every coordinate from
// coord_a towards coord_b, one point per valid/ready transfer.
module line_span_counter #(
   parameter int WIDTH       = 13,
   parameter bit INCLUDE_END = 1'b1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic                    abort,
   input  logic signed [WIDTH-1:0] coord_a,
   input  logic signed [WIDTH-1:0] coord_b,
   input  logic                    out_ready,
   output logic                    busy,
   output logic                    out_valid,
   output logic signed [WIDTH-1:0] coord,
   output logic                    last,
   output logic [WIDTH:0]          step_idx,
   output logic                    dir_down,
   output logic                    done
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t                  state_q, state_d;
   logic signed [WIDTH-1:0] coord_q, coord_d;
   logic signed [WIDTH-1:0] end_q, end_d;
   logic [WIDTH:0]          step_idx_q, step_idx_d;
   logic                    last_q, last_d;
   logic                    dir_down_q, dir_down_d;
   logic                    out_valid_q, out_valid_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;

   logic signed [WIDTH:0]   span_diff, span_len;
   logic signed [WIDTH:0]   step_ext, coord_next_ext, end_ext;
   logic                    next_is_last;

   // Span arithmetic is done one bit wider so a full-range span cannot overflow.
   always_comb begin
      span_diff      = {coord_b[WIDTH-1], coord_b} - {coord_a[WIDTH-1], coord_a};
      span_len       = (span_diff < 0) ? -span_diff : span_diff;
      step_ext       = dir_down_q ? {(WIDTH+1){1'b1}} : {{WIDTH{1'b0}}, 1'b1};
      coord_next_ext = {coord_q[WIDTH-1], coord_q} + step_ext;
      end_ext        = {end_q[WIDTH-1], end_q};
      if (INCLUDE_END)
         next_is_last = (coord_next_ext == end_ext);
      else
         next_is_last = ((coord_next_ext + step_ext) == end_ext);
   end

   always_comb begin
      state_d     = state_q;
      coord_d     = coord_q;
      end_d       = end_q;
      step_idx_d  = step_idx_q;
      last_d      = last_q;
      dir_down_d  = dir_down_q;
      out_valid_d = out_valid_q;
      busy_d      = busy_q;
      done_d      = 1'b0;

      if (abort) begin
         state_d     = IDLE;
         out_valid_d = 1'b0;
         last_d      = 1'b0;
         busy_d      = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               // A start coinciding with the done pulse is deliberately dropped.
               if (start && !done_q) begin
                  end_d      = coord_b;
                  dir_down_d = (coord_b < coord_a);
                  coord_d    = coord_a;
                  step_idx_d = '0;
                  if (!INCLUDE_END && (span_len == '0)) begin
                     done_d = 1'b1;
                     last_d = 1'b0;
                  end else begin
                     state_d     = RUN;
                     out_valid_d = 1'b1;
                     busy_d      = 1'b1;
                     if (INCLUDE_END)
                        last_d = (coord_a == coord_b);
                     else
                        last_d = (span_len == {{WIDTH{1'b0}}, 1'b1});
                  end
               end
            end
            RUN: begin
               if (out_valid_q && out_ready) begin
                  if (last_q) begin
                     state_d     = IDLE;
                     out_valid_d = 1'b0;
                     last_d      = 1'b0;
                     busy_d      = 1'b0;
                     done_d      = 1'b1;
                  end else begin
                     coord_d    = coord_next_ext[WIDTH-1:0];
                     step_idx_d = step_idx_q + {{WIDTH{1'b0}}, 1'b1};
                     last_d     = next_is_last;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         coord_q     <= '0;
         end_q       <= '0;
         step_idx_q  <= '0;
         last_q      <= 1'b0;
         dir_down_q  <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         coord_q     <= coord_d;
         end_q       <= end_d;
         step_idx_q  <= step_idx_d;
         last_q      <= last_d;
         dir_down_q  <= dir_down_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign busy      = busy_q;
   assign out_valid = out_valid_q;
   assign coord     = coord_q;
   assign last      = last_q;
   assign step_idx  = step_idx_q;
   assign dir_down  = dir_down_q;
   assign done      = done_q;

endmodule

// File: tb/tb_line_span_counter.sv
// Bench for line_span_counter: an inclusive and an exclusive instance share the
// same stimulus and are checked every cycle against an index-based span model.
module tb_line_span_counter;

   localparam int W = 13;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic start = 1'b0;
   logic abort = 1'b0;
   logic out_ready = 1'b0;
   logic signed [W-1:0] coord_a = '0;
   logic signed [W-1:0] coord_b = '0;

   logic                d_busy     [2];
   logic                d_valid    [2];
   logic signed [W-1:0] d_coord    [2];
   logic                d_last     [2];
   logic [W:0]          d_step     [2];
   logic                d_dir_down [2];
   logic                d_done     [2];

   int  n_checks = 0;
   int  n_fail   = 0;
   bit  check_en = 1'b0;
   bit  toggle_ready = 1'b0;
   int  done_cnt [2];
   string pfx [2] = '{"inc", "exc"};

   always #5 clk = ~clk;

   line_span_counter #(.WIDTH(W), .INCLUDE_END(1'b1)) dut_inc (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .coord_a(coord_a), .coord_b(coord_b), .out_ready(out_ready),
      .busy(d_busy[0]), .out_valid(d_valid[0]), .coord(d_coord[0]),
      .last(d_last[0]), .step_idx(d_step[0]), .dir_down(d_dir_down[0]),
      .done(d_done[0]));

   line_span_counter #(.WIDTH(W), .INCLUDE_END(1'b0)) dut_exc (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .coord_a(coord_a), .coord_b(coord_b), .out_ready(out_ready),
      .busy(d_busy[1]), .out_valid(d_valid[1]), .coord(d_coord[1]),
      .last(d_last[1]), .step_idx(d_step[1]), .dir_down(d_dir_down[1]),
      .done(d_done[1]));

   // Model: a span is a list of m_n points a, a+dir, ...; m_idx selects the current one.
   bit m_inc   [2] = '{1'b1, 1'b0};
   bit m_valid [2];
   bit m_done  [2];
   bit m_dirdn [2];
   int m_a     [2];
   int m_dir   [2];
   int m_n     [2];
   int m_idx   [2];
   int mdl_a, mdl_b, mdl_n;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 2; i++) begin
            m_valid[i] <= 1'b0; m_done[i] <= 1'b0; m_dirdn[i] <= 1'b0;
            m_a[i] <= 0; m_dir[i] <= 0; m_n[i] <= 0; m_idx[i] <= 0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            m_done[i] <= 1'b0;
            if (abort) begin
               m_valid[i] <= 1'b0;
            end else if (!m_valid[i]) begin
               if (start && !m_done[i]) begin
                  mdl_a = int'(coord_a);
                  mdl_b = int'(coord_b);
                  mdl_n = ((mdl_b > mdl_a) ? mdl_b - mdl_a : mdl_a - mdl_b) + (m_inc[i] ? 1 : 0);
                  m_a[i]     <= mdl_a;
                  m_dir[i]   <= (mdl_b < mdl_a) ? -1 : 1;
                  m_dirdn[i] <= (mdl_b < mdl_a);
                  m_idx[i]   <= 0;
                  m_n[i]     <= mdl_n;
                  if (mdl_n == 0) m_done[i] <= 1'b1;
                  else            m_valid[i] <= 1'b1;
               end
            end else if (out_ready) begin
               if (m_idx[i] == m_n[i] - 1) begin
                  m_valid[i] <= 1'b0;
                  m_done[i]  <= 1'b1;
               end else begin
                  m_idx[i] <= m_idx[i] + 1;
               end
            end
         end
      end
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   always @(negedge clk) begin
      if (check_en) begin
         for (int i = 0; i < 2; i++) begin
            checkOutput({pfx[i], "_valid"}, int'(d_valid[i]), int'(m_valid[i]));
            checkOutput({pfx[i], "_busy"},  int'(d_busy[i]),  int'(m_valid[i]));
            checkOutput({pfx[i], "_coord"}, int'(d_coord[i]), m_a[i] + m_dir[i] * m_idx[i]);
            checkOutput({pfx[i], "_step"},  int'(d_step[i]),  m_idx[i]);
            checkOutput({pfx[i], "_last"},  int'(d_last[i]),
                        int'(m_valid[i] && (m_idx[i] == m_n[i] - 1)));
            checkOutput({pfx[i], "_dir"},   int'(d_dir_down[i]), int'(m_dirdn[i]));
            checkOutput({pfx[i], "_done"},  int'(d_done[i]),  int'(m_done[i]));
         end
      end
   end

   task automatic stepCycle();
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++)
         if (d_done[i]) done_cnt[i]++;
      start = 1'b0;
      abort = 1'b0;
      if (toggle_ready) out_ready = ~out_ready;
   endtask

   task automatic applyStimulus(input int a, input int b);
      @(posedge clk);
      #1;
      coord_a = W'(a);
      coord_b = W'(b);
      start   = 1'b1;
      done_cnt[0] = 0;
      done_cnt[1] = 0;
      stepCycle();
   endtask

   task automatic waitIdle(input int budget);
      bit idle;
      idle = 1'b0;
      for (int c = 0; c < budget && !idle; c++) begin
         stepCycle();
         idle = !d_valid[0] && !d_valid[1] && !d_done[0] && !d_done[1];
      end
      if (!idle) begin
         n_checks++;
         n_fail++;
         $display("[TB] FAIL wait_idle: still active after %0d cycles, expected idle", budget);
      end
   endtask

   initial begin
      done_cnt[0] = 0;
      done_cnt[1] = 0;
      #1 reset = 1'b1;
      #21 reset = 1'b0;
      checkOutput("rst_valid", int'(d_valid[0]), 0);
      checkOutput("rst_coord", int'(d_coord[1]), 0);
      checkOutput("rst_step",  int'(d_step[0]), 0);
      checkOutput("rst_done",  int'(d_done[1]), 0);
      check_en  = 1'b1;
      out_ready = 1'b1;

      // Ascending 3..7 at full throughput.
      applyStimulus(3, 7);
      checkOutput("t1_first_coord", int'(d_coord[0]), 3);
      checkOutput("t1_first_step",  int'(d_step[0]), 0);
      waitIdle(50);
      checkOutput("t1_inc_final", int'(d_coord[0]), 7);
      checkOutput("t1_inc_step",  int'(d_step[0]), 4);
      checkOutput("t1_exc_final", int'(d_coord[1]), 6);
      checkOutput("t1_done_cnt",  done_cnt[0], 1);

      // Descending 5..-2 with toggling backpressure.
      toggle_ready = 1'b1;
      applyStimulus(5, -2);
      checkOutput("t2_first_coord", int'(d_coord[0]), 5);
      checkOutput("t2_dir_down",    int'(d_dir_down[0]), 1);
      waitIdle(100);
      checkOutput("t2_inc_final", int'(d_coord[0]), -2);
      checkOutput("t2_inc_step",  int'(d_step[0]), 7);
      checkOutput("t2_done_cnt",  done_cnt[0], 1);
      toggle_ready = 1'b0;
      out_ready    = 1'b1;

      // Zero-length span.
      applyStimulus(10, 10);
      checkOutput("t3_inc_valid", int'(d_valid[0]), 1);
      checkOutput("t3_inc_last",  int'(d_last[0]), 1);
      checkOutput("t3_exc_valid", int'(d_valid[1]), 0);
      checkOutput("t3_exc_done",  int'(d_done[1]), 1);
      waitIdle(20);
      checkOutput("t3_inc_done_cnt", done_cnt[0], 1);

      // Half-open 0..4 never emits 4 on the exclusive instance.
      applyStimulus(0, 4);
      waitIdle(50);
      checkOutput("t4_exc_final", int'(d_coord[1]), 3);
      checkOutput("t4_exc_step",  int'(d_step[1]), 3);
      checkOutput("t4_inc_final", int'(d_coord[0]), 4);

      // Full signed range.
      applyStimulus(-4096, 4095);
      waitIdle(9000);
      checkOutput("t5_inc_final", int'(d_coord[0]), 4095);
      checkOutput("t5_inc_step",  int'(d_step[0]), 8191);
      checkOutput("t5_exc_final", int'(d_coord[1]), 4094);
      checkOutput("t5_exc_step",  int'(d_step[1]), 8190);

      // Abort on the third point.
      applyStimulus(0, 9);
      stepCycle();
      stepCycle();
      checkOutput("t6_third_coord", int'(d_coord[0]), 2);
      abort = 1'b1;
      stepCycle();
      checkOutput("t6_valid", int'(d_valid[0]), 0);
      checkOutput("t6_busy",  int'(d_busy[1]), 0);
      checkOutput("t6_hold",  int'(d_coord[0]), 2);
      stepCycle();
      checkOutput("t6_no_done", done_cnt[0] + done_cnt[1], 0);

      // Start during RUN is ignored.
      applyStimulus(20, 30);
      stepCycle();
      coord_a = W'(-50);
      coord_b = W'(-60);
      start   = 1'b1;
      stepCycle();
      checkOutput("t7_coord", int'(d_coord[0]), 22);
      checkOutput("t7_dir",   int'(d_dir_down[0]), 0);
      waitIdle(50);
      checkOutput("t7_final", int'(d_coord[0]), 30);

      // Async reset mid-span, then a fresh span.
      applyStimulus(100, 110);
      stepCycle();
      stepCycle();
      #2 reset = 1'b1;
      #1;
      checkOutput("t8_valid", int'(d_valid[0]), 0);
      checkOutput("t8_coord", int'(d_coord[0]), 0);
      checkOutput("t8_step",  int'(d_step[1]), 0);
      #3 reset = 1'b0;
      applyStimulus(-3, 1);
      waitIdle(50);
      checkOutput("t8_inc_final", int'(d_coord[0]), 1);
      checkOutput("t8_inc_step",  int'(d_step[0]), 4);
      checkOutput("t8_exc_final", int'(d_coord[1]), 0);

      check_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
